// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer.
// Holds the state encoding, opcodes, ALU class codes and the mux-select encodings.
// The helper is_req_state identifies the states that own the memory port.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_R_WB      = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU class codes consumed by the ALU decoder (001 doubles as plain ADD)
    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_LW  = 3'b001;
    localparam logic [2:0] ALU_SW  = 3'b010;
    localparam logic [2:0] ALU_BEQ = 3'b011;
    localparam logic [2:0] ALU_BNE = 3'b100;
    localparam logic [2:0] ALU_J   = 3'b101;

    // pc_src encodings
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    function automatic logic is_req_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited unanswered; expire flags the last allowed cycle.
// Latency: expire is combinational from the count register; count/clear take effect next cycle.
// Ports: clk, rst (async, active-high), clear (restart at 0, wins over count), count (+1), expire.
module mem_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (count) begin
            wait_cnt <= wait_cnt + W'(1);
        end
    end

    // wait_cnt counts completed unanswered cycles, so the WAIT_MAX-th request cycle sees WAIT_MAX-1
    assign expire = (wait_cnt == W'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS main sequencer: FETCH/DECODE/EXEC/MEM/WB over one ALU and one memory port.
// Latency: outputs are combinational from state (plus mem_ready/zero); one state per clock.
// Backpressure: mem_req and iord/mem_we hold until mem_ready or until the wait timer expires.
// Ports: clk, rst; opcode, zero, mem_ready in; mem_req, mem_we, iord, ir_write, pc_en, pc_src,
//        alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, illegal_op,
//        bus_timeout, retired out.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic             bus_timeout,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t state_nxt;
    logic   retire;
    logic   expire;
    logic   timer_clear;
    logic   timer_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = PC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REGB;
        alu_ctrl    = ALU_R;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        illegal_op  = 1'b0;
        bus_timeout = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_LW;
                // ready on the expiry cycle still completes the fetch
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (expire) begin
                    bus_timeout = 1'b1;
                    state_nxt   = S_FETCH;
                end
            end
            S_DECODE: begin
                // speculative branch target PC + (imm<<2) lands in ALUOut
                alu_src_b = SRCB_IMM_SH;
                alu_ctrl  = ALU_LW;
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC_R;
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_BEQ,
                    OP_BNE:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                alu_ctrl  = ALU_R;
                state_nxt = S_R_WB;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_SW) begin
                    alu_ctrl  = ALU_SW;
                    state_nxt = S_MEM_WRITE;
                end else begin
                    alu_ctrl  = ALU_LW;
                    state_nxt = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_MEM_WB;
                end else if (expire) begin
                    bus_timeout = 1'b1;
                    state_nxt   = S_FETCH;
                end
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (expire) begin
                    bus_timeout = 1'b1;
                    state_nxt   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                pc_src    = PC_ALUOUT;
                if (opcode == OP_BEQ) begin
                    alu_ctrl = ALU_BEQ;
                    pc_en    = zero;
                end else begin
                    alu_ctrl = ALU_BNE;
                    pc_en    = ~zero;
                end
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = PC_JUMP;
                pc_en     = 1'b1;
                alu_ctrl  = ALU_J;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        // reset drops every output, including an in-flight mem_req, at once
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            iord        = 1'b0;
            ir_write    = 1'b0;
            pc_en       = 1'b0;
            pc_src      = PC_ALU;
            alu_src_a   = 1'b0;
            alu_src_b   = SRCB_REGB;
            alu_ctrl    = ALU_R;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            illegal_op  = 1'b0;
            bus_timeout = 1'b0;
            retire      = 1'b0;
        end
    end

    // Restart the wait count whenever a request state is (re-)entered, including FETCH->FETCH retry
    assign timer_clear = is_req_state(state_nxt) && ((state_nxt != state) || bus_timeout);
    assign timer_count = mem_req && !mem_ready;

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .count  (timer_count),
        .expire (expire)
    );

endmodule
